// File: rtl/fm_radio_pkg.sv
// Shared definitions for the FM radio datapath: Q10 fixed-point helpers,
// audio low-pass coefficients and the decimating FIR state encoding.
package fm_radio_pkg;

  localparam int unsigned FRAC_BITS    = 10;
  localparam int unsigned SAMPLE_WIDTH = 32;
  localparam int unsigned AUDIO_TAPS   = 32;

  typedef logic signed [AUDIO_TAPS-1:0][SAMPLE_WIDTH-1:0] coeff_arr_t;

  // Symmetric Q10 low-pass; symmetry makes the pattern ordering irrelevant.
  localparam coeff_arr_t AUDIO_LPR_COEFFS = '{
    32'sd1,  32'sd2,  32'sd4,  32'sd7,  32'sd11, 32'sd16, 32'sd22, 32'sd29,
    32'sd36, 32'sd43, 32'sd49, 32'sd54, 32'sd58, 32'sd61, 32'sd63, 32'sd64,
    32'sd64, 32'sd63, 32'sd61, 32'sd58, 32'sd54, 32'sd49, 32'sd43, 32'sd36,
    32'sd29, 32'sd22, 32'sd16, 32'sd11, 32'sd7,  32'sd4,  32'sd2,  32'sd1
  };

  typedef enum logic [1:0] {
    S_SHIFT,
    S_MAC,
    S_OUTPUT
  } fir_state_e;

  function automatic logic signed [SAMPLE_WIDTH-1:0] quantize(
      input logic signed [SAMPLE_WIDTH-1:0] v, input int unsigned frac);
    return v <<< frac;
  endfunction

  // Rounds toward zero: bias negative values before the arithmetic shift.
  function automatic logic signed [SAMPLE_WIDTH-1:0] dequantize(
      input logic signed [SAMPLE_WIDTH-1:0] v, input int unsigned frac);
    logic signed [SAMPLE_WIDTH-1:0] bias;
    bias = v[SAMPLE_WIDTH-1] ? (SAMPLE_WIDTH'(1) << frac) - SAMPLE_WIDTH'(1) : '0;
    return (v + bias) >>> frac;
  endfunction

endpackage

// File: rtl/fir_decimate.sv
// Decimating real FIR low-pass behind the FM demodulator: collects DECIM
// samples, then runs one MAC per cycle over all taps and pushes one result.
module fir_decimate #(
  parameter int unsigned TAPS       = 32,
  parameter int unsigned DECIM      = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 10,
  parameter logic [TAPS*DATA_WIDTH-1:0] COEFFS = fm_radio_pkg::AUDIO_LPR_COEFFS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         fifo_in_empty,
  output logic                         rd_en_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         wr_en_out,
  input  logic                         fifo_out_full
);
  import fm_radio_pkg::*;

  localparam int unsigned TapW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned CntW = (DECIM > 1) ? $clog2(DECIM) : 1;

  fir_state_e                   state_q, state_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [TapW-1:0]              tap_q, tap_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
  logic signed [DATA_WIDTH-1:0] x_q [TAPS];
  logic                         shift_en;

  logic signed [DATA_WIDTH-1:0] coeff;
  logic signed [DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0] acc_sum;

  // Same-width signed multiply keeps only the low DATA_WIDTH product bits.
  assign coeff   = COEFFS[int'(tap_q)*DATA_WIDTH +: DATA_WIDTH];
  assign prod    = x_q[tap_q] * coeff;
  assign acc_sum = acc_q + dequantize(prod, FRAC_BITS);

  assign data_out = dout_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    dout_d    = dout_q;
    shift_en  = 1'b0;
    rd_en_in  = 1'b0;
    wr_en_out = 1'b0;
    unique case (state_q)
      S_SHIFT: begin
        // Gated by reset so no pop is requested while the block is held in reset.
        if (reset && !fifo_in_empty) begin
          rd_en_in = 1'b1;
          shift_en = 1'b1;
          if (cnt_q == CntW'(DECIM - 1)) begin
            cnt_d   = '0;
            acc_d   = '0;
            tap_d   = '0;
            state_d = S_MAC;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        tap_d = tap_q + TapW'(1);
        if (tap_q == TapW'(TAPS - 1)) begin
          tap_d   = '0;
          dout_d  = acc_sum;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (!fifo_out_full) begin
          wr_en_out = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      default: state_d = S_SHIFT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_SHIFT;
      cnt_q   <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      for (int i = 0; i < int'(TAPS); i++) x_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      if (shift_en) begin
        x_q[0] <= data_in;
        for (int i = 1; i < int'(TAPS); i++) x_q[i] <= x_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fir_decimate.sv
// Bench for fir_decimate: three instances (ramp, production, constant-512
// coefficients) share one input stream and are checked against a sum-of-products model.
module tb_fir_decimate;
  import fm_radio_pkg::*;

  localparam int TAPS  = 32;
  localparam int DECIM = 8;
  localparam int NDUT  = 3;

  function automatic logic [TAPS*32-1:0] fill_coeffs(input int kind);
    logic [TAPS*32-1:0] v;
    v = '0;
    for (int i = 0; i < TAPS; i++) v[i*32 +: 32] = (kind == 0) ? 32'(i + 1) : 32'd512;
    return v;
  endfunction

  localparam logic [TAPS*32-1:0] H_RAMP = fill_coeffs(0);
  localparam logic [TAPS*32-1:0] H_HALF = fill_coeffs(1);

  logic        clock = 1'b0;
  logic        reset;
  logic        fifo_in_empty;
  logic        fifo_out_full;
  logic [31:0] data_in;
  logic        rd_en [NDUT];
  logic        wr_en [NDUT];
  logic [31:0] dout  [NDUT];

  always #5 clock = ~clock;

  fir_decimate #(.COEFFS(H_RAMP)) dut_ramp (
    .clock(clock), .reset(reset), .fifo_in_empty(fifo_in_empty), .rd_en_in(rd_en[0]),
    .data_in(data_in), .data_out(dout[0]), .wr_en_out(wr_en[0]),
    .fifo_out_full(fifo_out_full)
  );
  fir_decimate dut_prod (
    .clock(clock), .reset(reset), .fifo_in_empty(fifo_in_empty), .rd_en_in(rd_en[1]),
    .data_in(data_in), .data_out(dout[1]), .wr_en_out(wr_en[1]),
    .fifo_out_full(fifo_out_full)
  );
  fir_decimate #(.COEFFS(H_HALF)) dut_half (
    .clock(clock), .reset(reset), .fifo_in_empty(fifo_in_empty), .rd_en_in(rd_en[2]),
    .data_in(data_in), .data_out(dout[2]), .wr_en_out(wr_en[2]),
    .fifo_out_full(fifo_out_full)
  );

  int hcoef [NDUT][TAPS];
  int hist[$];
  int expq [NDUT][$];
  int obs  [NDUT][$];
  int rd8_cyc[$];
  int nreads = 0;
  int cyc = 0;
  bit lat_exact = 1'b1;
  int checks = 0;
  int errors = 0;

  function automatic void check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endfunction

  // Direct convolution of everything read since reset; older samples are zero.
  function automatic int filt(input int d);
    int n, y, p;
    longint x;
    n = hist.size();
    y = 0;
    for (int t = 0; t < TAPS; t++) begin
      x = (n - 1 - t >= 0) ? longint'(hist[n-1-t]) : 64'sd0;
      p = int'(x * longint'(hcoef[d][t]));
      y += p / (1 << FRAC_BITS);  // int division truncates toward zero
    end
    return y;
  endfunction

  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      hist.delete();
      rd8_cyc.delete();
      nreads = 0;
      for (int d = 0; d < NDUT; d++) begin
        expq[d].delete();
        obs[d].delete();
      end
    end else begin
      check("rd_while_empty", int'((rd_en[0] | rd_en[1] | rd_en[2]) & fifo_in_empty), 0);
      check("wr_while_full", int'((wr_en[0] | wr_en[1] | wr_en[2]) & fifo_out_full), 0);
      if (rd_en[0]) begin
        hist.push_back(int'(data_in));
        nreads++;
        if (nreads % DECIM == 0) begin
          for (int d = 0; d < NDUT; d++) expq[d].push_back(filt(d));
          rd8_cyc.push_back(cyc);
        end
      end
      for (int d = 0; d < NDUT; d++) begin
        if (wr_en[d]) begin
          check("wr_expected", int'(expq[d].size() > 0), 1);
          if (expq[d].size() > 0) check("dout_model", int'(dout[d]), expq[d].pop_front());
          obs[d].push_back(int'(dout[d]));
          if (d == 0 && rd8_cyc.size() > 0) begin
            int r;
            r = rd8_cyc.pop_front();
            if (lat_exact) check("latency", cyc - r, TAPS + 1);
          end
        end
      end
    end
  end

  task automatic send(input int v);
    bit taken;
    int n;
    data_in = v;
    fifo_in_empty = 1'b0;
    taken = 1'b0;
    n = 0;
    while (!taken && n < 100) begin
      @(negedge clock);
      taken = rd_en[0];
      @(posedge clock);
      #1;
      n++;
    end
    if (!taken) check("send_timeout", 0, 1);
    fifo_in_empty = 1'b1;
  endtask

  task automatic idle(input int n);
    fifo_in_empty = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_outputs(input int n);
    for (int i = 0; i < 200 && obs[0].size() < n; i++) @(posedge clock);
    #1;
    check("wait_outputs", int'(obs[0].size() >= n), 1);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    fifo_in_empty = 1'b1;
    fifo_out_full = 1'b0;
    lat_exact = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, lim;
    int hold_exp [NDUT];
    for (int i = 0; i < TAPS; i++) begin
      hcoef[0][i] = i + 1;
      hcoef[1][i] = int'(AUDIO_LPR_COEFFS[i]);
      hcoef[2][i] = 512;
    end
    reset = 1'b0;
    fifo_in_empty = 1'b0;
    fifo_out_full = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check("reset_dout", int'(dout[d]), 0);
      check("reset_wr", int'(wr_en[d]), 0);
      check("reset_rd", int'(rd_en[d]), 0);
    end
    fifo_in_empty = 1'b1;
    reset = 1'b1;

    // Impulse through ramp coefficients
    send(1024);
    repeat (31) send(0);
    wait_outputs(4);
    for (int k = 0; k < 4; k++) check("impulse", obs[0][k], 8 * (k + 1));

    // Same impulse with the input FIFO empty between every sample
    do_reset();
    send(1024);
    idle(1);
    for (int i = 0; i < 31; i++) begin
      send(0);
      idle(1);
    end
    wait_outputs(4);
    for (int k = 0; k < 4; k++) check("starved_impulse", obs[0][k], 8 * (k + 1));

    // DC input: partial sums while the delay line fills, then the full sum
    do_reset();
    repeat (6 * DECIM) send(1024);
    wait_outputs(6);
    for (int k = 0; k < 6; k++) begin
      s = 0;
      lim = (DECIM * (k + 1) < TAPS) ? DECIM * (k + 1) : TAPS;
      for (int t = 0; t < lim; t++) s += hcoef[1][t];
      check("dc_sum", obs[1][k], s);
    end

    // Negative products round toward zero
    do_reset();
    repeat (DECIM) send(-1);
    wait_outputs(1);
    check("round_half", obs[2][0], 0);
    check("round_ramp", obs[0][0], 0);

    // Backpressure held for 20 cycles in the output state
    do_reset();
    lat_exact = 1'b0;
    fifo_out_full = 1'b1;
    repeat (DECIM) send(int'($urandom_range(0, 200000)) - 100000);
    for (int d = 0; d < NDUT; d++) hold_exp[d] = filt(d);
    repeat (TAPS) @(posedge clock);
    #1;
    fifo_in_empty = 1'b0;
    repeat (20) begin
      @(negedge clock);
      for (int d = 0; d < NDUT; d++) begin
        check("bp_wr", int'(wr_en[d]), 0);
        check("bp_rd", int'(rd_en[d]), 0);
        check("bp_dout", int'(dout[d]), hold_exp[d]);
      end
    end
    @(posedge clock);
    #1;
    fifo_out_full = 1'b0;
    @(negedge clock);
    for (int d = 0; d < NDUT; d++) check("bp_release_wr", int'(wr_en[d]), 1);
    @(posedge clock);
    #1;
    fifo_in_empty = 1'b1;
    @(negedge clock);
    for (int d = 0; d < NDUT; d++) check("bp_single_wr", int'(wr_en[d]), 0);
    check("bp_count", obs[0].size(), 1);
    lat_exact = 1'b1;

    // Reset in the middle of the MAC pass
    do_reset();
    repeat (DECIM) send(int'($urandom));
    repeat (10) @(posedge clock);
    #1;
    fifo_in_empty = 1'b0;
    reset = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check("midmac_dout", int'(dout[d]), 0);
      check("midmac_wr", int'(wr_en[d]), 0);
      check("midmac_rd", int'(rd_en[d]), 0);
    end
    repeat (2) @(posedge clock);
    #1;
    fifo_in_empty = 1'b1;
    reset = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    check("midmac_no_write", obs[0].size(), 0);
    repeat (DECIM) send(int'($urandom));
    wait_outputs(1);
    check("midmac_fresh", obs[0].size(), 1);

    // Random samples with random gaps, all instances against the model
    do_reset();
    for (int i = 0; i < 8 * DECIM; i++) begin
      send(int'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    wait_outputs(8);

    repeat (5) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_decimate.md
Name: fir_decimate

Overview:
- Real-valued decimating FIR low-pass placed directly downstream of the FM demodulator.
- Consumes Q10 demodulated samples from the demod output FIFO.
- Emits one filtered audio sample per DECIM input samples into an output FIFO that feeds the later audio stages.
- Uses one shared multiplier, one MAC per cycle.

Parameters:
- TAPS, 32, number of filter coefficients (multiple of DECIM).
- DECIM, 8, decimation factor (input samples consumed per output).
- DATA_WIDTH, 32, sample/coefficient width, signed.
- FRAC_BITS, 10, fixed-point fraction bits (Q10 quantization).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- fifo_in_empty  in  1  input FIFO empty flag.
- rd_en_in  out  1  pop strobe to input FIFO; data is valid same cycle (FWFT).
- data_in  in  DATA_WIDTH  signed Q10 demodulated sample.
- data_out  out  DATA_WIDTH  signed Q10 filtered, decimated sample.
- wr_en_out  out  1  push strobe to output FIFO.
- fifo_out_full  in  1  output FIFO full flag.

Behaviour:
- Reset (reset=0, async): state=S_SHIFT, delay line x[0..TAPS-1]=0, decim count=0, accumulator=0, tap index=0, data_out=0, rd_en_in=0, wr_en_out=0.
- Delay line: newest sample at x[0]. Each accepted sample shifts x[i]<=x[i-1] and x[0]<=data_in.
- S_SHIFT:
  - rd_en_in = !fifo_in_empty (combinational). On a read: shift, count++.
  - When count reaches DECIM-1 and a read occurs: count<=0, acc<=0, tap<=0, go S_MAC.
  - No read while empty; hold state.
- S_MAC:
  - One tap per cycle: acc <= acc + DEQUANTIZE(low32(x[tap]*h[tap])), tap++.
  - After tap TAPS-1 is accumulated, latch data_out <= final acc and go S_OUTPUT.
  - Takes exactly TAPS cycles. rd_en_in=0 throughout.
- S_OUTPUT:
  - If !fifo_out_full: wr_en_out=1 for one cycle, go S_SHIFT.
  - Else hold with data_out stable, wr_en_out=0, no reads.
- Arithmetic:
  - Signed DATA_WIDTH x DATA_WIDTH product; low DATA_WIDTH bits kept.
  - DEQUANTIZE rounds toward zero: if negative, add 2^FRAC_BITS-1, then arithmetic shift right FRAC_BITS.
  - Accumulator is DATA_WIDTH, two's-complement wrap, no saturation.
- Latency: last input read of a group to wr_en_out is TAPS+1 cycles minimum (TAPS MAC cycles, then the write cycle), plus backpressure stall.
- Throughput: at most one output per DECIM+TAPS+1 cycles.
- First output requires DECIM reads; the delay line starts zero-filled (no warm-up suppression).
- data_out changes only when entering S_OUTPUT; otherwise it holds.
- Simultaneous fifo_in_empty deassert and S_MAC: ignored until S_SHIFT.
- Reset mid-MAC or mid-OUTPUT: the in-flight result is discarded and no write is issued.

Decomposition:
- Shared package fm_radio_pkg holds:
  - QUANTIZE/DEQUANTIZE functions and FRAC_BITS constant (shared with the demod stage).
  - Coefficient array type and AUDIO_LPR_COEFFS constant (TAPS entries, Q10).
  - State enum {S_SHIFT, S_MAC, S_OUTPUT}.
- No sub-module: a single module with a combinational next-state block and one register block.

Test Plan:
- Impulse: with test coefficients h[i]=i+1 (Q10 integers), feed 1024 then 31 zeros, fifo_out_full=0.
  - Outputs are DEQ(1024*h[7])=8, then 16, 24, 32.
  - Each wr_en_out occurs exactly TAPS+1=33 cycles after the 8th read of its group.
- DC: constant input 1024, production coeffs.
  - 4th and later outputs equal the sum of AUDIO_LPR_COEFFS.
  - Outputs 1-3 equal the partial sums over the taps filled so far.
- Rounding: h all = 512, input -1.
  - Every product -512 dequantizes to 0, so output = 0, not -32.
- Backpressure: hold fifo_out_full=1 for 20 cycles in S_OUTPUT.
  - wr_en_out=0 and rd_en_in=0 throughout, data_out constant.
  - A single write occurs the cycle full drops.
- Input starvation: assert fifo_in_empty between every sample.
  - rd_en_in never asserts while empty, no samples are lost.
  - Output values match the unstalled run.
- Reset mid-MAC: drive reset=0 at tap 10.
  - data_out=0 and wr_en_out=0 immediately (async), delay line cleared.
  - After release, the next output needs 8 fresh reads.
